branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 38 +++
 rtl/bp_table.sv | 46 ++++
 rtl/branch_predictor.sv | 151 +++++++++++++++
 tb/tb_branch_predictor.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and sizing for the direct-mapped branch predictor.
package bp_pkg;

  localparam int unsigned ENTRIES_DEFAULT = 64;

  // Index and tag widths for the default table size. PC bits [1:0] are never used.
  localparam int unsigned IDX_W = $clog2(ENTRIES_DEFAULT);
  localparam int unsigned TAG_W = 30 - IDX_W;

  // Tag field is sized for the smallest legal table (4 entries, 28 tag bits); smaller
  // tags are stored zero-extended so one struct serves every ENTRIES value.
  localparam int unsigned TAG_MAX_W = 28;

  // 2-bit saturating direction counter; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    CtrSnt = 2'd0,
    CtrWnt = 2'd1,
    CtrWt  = 2'd2,
    CtrSt  = 2'd3
  } bp_ctr_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic                 jump;
    bp_ctr_t              ctr;
  } bp_entry_t;

  localparam bp_entry_t ENTRY_RESET = '{
    valid:  1'b0,
    tag:    '0,
    target: 32'h0,
    jump:   1'b0,
    ctr:    CtrWnt
  };

endpackage

// File: rtl/bp_table.sv
// Predictor entry array: two asynchronous read ports (fetch lookup, EX update) and one
// write port committed on the rising clock edge.
module bp_table
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = ENTRIES_DEFAULT,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [IDX_W-1:0] rd_idx_f,
  output bp_entry_t        rd_entry_f,
  input  logic [IDX_W-1:0] rd_idx_e,
  output bp_entry_t        rd_entry_e,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  bp_entry_t        wr_entry
);

  bp_entry_t entry_q [ENTRIES];
  bp_entry_t entry_d [ENTRIES];

  // Next-state array: only the addressed entry changes on a write.
  always_comb begin
    entry_d = entry_q;
    if (wr_en) begin
      entry_d[wr_idx] = wr_entry;
    end
  end

  // Entry storage; reset clears the whole array immediately and overrides any write.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entry_q[i] <= ENTRY_RESET;
      end
    end else begin
      entry_q <= entry_d;
    end
  end

  // Reads return the registered contents, so a same-cycle write is not visible yet.
  assign rd_entry_f = entry_q[rd_idx_f];
  assign rd_entry_e = entry_q[rd_idx_e];

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with BTB target, 2-bit direction counters, EX-stage
// mispredict detection/redirect and resolved/mispredict statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = ENTRIES_DEFAULT
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  input  logic        upd_valid_e,
  input  logic [31:0] upd_pc_e,
  input  logic        upd_taken_e,
  input  logic [31:0] upd_target_e,
  input  logic        upd_jump_e,
  input  logic        pred_taken_e,
  input  logic [31:0] pred_target_e,
  output logic        mispredict_e,
  output logic [31:0] redirect_pc_e,
  output logic        flush_d,
  output logic        flush_e,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  localparam int unsigned IdxW = $clog2(ENTRIES);

  logic [IdxW-1:0]      f_idx;
  logic [IdxW-1:0]      e_idx;
  logic [TAG_MAX_W-1:0] f_tag;
  logic [TAG_MAX_W-1:0] e_tag;
  bp_entry_t            f_entry;
  bp_entry_t            e_entry;
  logic                 f_hit;
  logic                 e_hit;
  bp_ctr_t              ctr_next;
  logic                 wr_en;
  bp_entry_t            wr_entry;
  logic [31:0]          br_count_d, br_count_q;
  logic [31:0]          mp_count_d, mp_count_q;
  logic                 unused_pc_lsb;

  assign f_idx = pc_f[IdxW+1:2];
  assign e_idx = upd_pc_e[IdxW+1:2];
  assign f_tag = TAG_MAX_W'(pc_f[31:IdxW+2]);
  assign e_tag = TAG_MAX_W'(upd_pc_e[31:IdxW+2]);

  // Byte offset within the word carries no information for a 4-byte aligned ISA.
  assign unused_pc_lsb = ^{pc_f[1:0], upd_pc_e[1:0]};

  bp_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IdxW)
  ) u_bp_table (
    .clk        (clk),
    .n_rst      (n_rst),
    .rd_idx_f   (f_idx),
    .rd_entry_f (f_entry),
    .rd_idx_e   (e_idx),
    .rd_entry_e (e_entry),
    .wr_en      (wr_en),
    .wr_idx     (e_idx),
    .wr_entry   (wr_entry)
  );

  // Fetch lookup: jumps always predict taken, conditionals follow the counter MSB.
  always_comb begin
    f_hit         = f_entry.valid && (f_entry.tag == f_tag);
    pred_taken_f  = f_hit && (f_entry.jump || f_entry.ctr[1]);
    pred_target_f = pred_taken_f ? f_entry.target : pc_f + 32'd4;
  end

  // Saturating counter step for the resolved instruction's entry.
  always_comb begin
    ctr_next = e_entry.ctr;
    if (upd_taken_e) begin
      if (e_entry.ctr != CtrSt) begin
        ctr_next = bp_ctr_t'(e_entry.ctr + 2'd1);
      end
    end else begin
      if (e_entry.ctr != CtrSnt) begin
        ctr_next = bp_ctr_t'(e_entry.ctr - 2'd1);
      end
    end
  end

  // Table update: train on hit, allocate only on a taken miss.
  always_comb begin
    e_hit    = e_entry.valid && (e_entry.tag == e_tag);
    wr_en    = 1'b0;
    wr_entry = e_entry;
    if (upd_valid_e) begin
      if (e_hit) begin
        wr_en = 1'b1;
        if (!upd_jump_e) begin
          wr_entry.ctr = ctr_next;
        end
        if (upd_taken_e) begin
          wr_entry.target = upd_target_e;
          wr_entry.jump   = upd_jump_e;
        end
      end else if (upd_taken_e) begin
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = e_tag;
        wr_entry.target = upd_target_e;
        wr_entry.jump   = upd_jump_e;
        wr_entry.ctr    = upd_jump_e ? CtrSt : CtrWt;
      end
    end
  end

  // Mispredict detection and redirect, resolved in the same cycle as the update.
  always_comb begin
    mispredict_e  = upd_valid_e &&
                    ((pred_taken_e != upd_taken_e) ||
                     (upd_taken_e && (pred_target_e != upd_target_e)));
    redirect_pc_e = upd_taken_e ? upd_target_e : upd_pc_e + 32'd4;
    flush_d       = mispredict_e;
    flush_e       = mispredict_e;
  end

  // Statistics next-state; both counters wrap naturally at 32 bits.
  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (upd_valid_e) begin
      br_count_d = br_count_q + 32'd1;
    end
    if (mispredict_e) begin
      mp_count_d = mp_count_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      br_count_q <= 32'h0;
      mp_count_q <= 32'h0;
    end else begin
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES = 64).
module tb_branch_predictor;

  logic        clk;
  logic        n_rst;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        upd_valid_e;
  logic [31:0] upd_pc_e;
  logic        upd_taken_e;
  logic [31:0] upd_target_e;
  logic        upd_jump_e;
  logic        pred_taken_e;
  logic [31:0] pred_target_e;
  logic        mispredict_e;
  logic [31:0] redirect_pc_e;
  logic        flush_d;
  logic        flush_e;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Saturation sequence: outcome per update and the prediction expected afterwards.
  // Counter path: alloc WT, ST, ST, WT, WNT, SNT, SNT, WNT, WT.
  logic sat_taken [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic sat_pred  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  branch_predictor #(.ENTRIES(64)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .pc_f          (pc_f),
    .pred_taken_f  (pred_taken_f),
    .pred_target_f (pred_target_f),
    .upd_valid_e   (upd_valid_e),
    .upd_pc_e      (upd_pc_e),
    .upd_taken_e   (upd_taken_e),
    .upd_target_e  (upd_target_e),
    .upd_jump_e    (upd_jump_e),
    .pred_taken_e  (pred_taken_e),
    .pred_target_e (pred_target_e),
    .mispredict_e  (mispredict_e),
    .redirect_pc_e (redirect_pc_e),
    .flush_d       (flush_d),
    .flush_e       (flush_e),
    .br_count      (br_count),
    .mp_count      (mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic taken,
                         input logic [31:0] tgt, input logic jump, input logic ptaken,
                         input logic [31:0] ptgt);
    upd_valid_e   = v;
    upd_pc_e      = pc;
    upd_taken_e   = taken;
    upd_target_e  = tgt;
    upd_jump_e    = jump;
    pred_taken_e  = ptaken;
    pred_target_e = ptgt;
  endtask

  // One-cycle update committed at the next rising edge; returns just after that edge.
  task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic jump, input logic ptaken, input logic [31:0] ptgt);
    @(negedge clk);
    set_upd(1'b1, pc, taken, tgt, jump, ptaken, ptgt);
    @(posedge clk);
    #1;
    upd_valid_e = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    pc_f = 32'h1000_0000;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pred_taken_f !== 1'b0) begin
      n_fail++; $display("FAIL reset_pred_taken: got %0b want 0", pred_taken_f);
    end
    n_checks++;
    if (pred_target_f !== 32'h1000_0004) begin
      n_fail++; $display("FAIL reset_pred_target: got %h want 10000004", pred_target_f);
    end
    n_checks++;
    if (br_count !== 32'h0 || mp_count !== 32'h0) begin
      n_fail++; $display("FAIL reset_counts: got br=%0d mp=%0d want 0 0", br_count, mp_count);
    end
    n_checks++;
    if (mispredict_e !== 1'b0 || flush_d !== 1'b0 || flush_e !== 1'b0) begin
      n_fail++; $display("FAIL reset_mispredict: got mp=%0b fd=%0b fe=%0b want 0 0 0",
                         mispredict_e, flush_d, flush_e);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (pred_taken_f !== 1'b0 || pred_target_f !== 32'h1000_0004) begin
      n_fail++; $display("FAIL post_reset_lookup: got %0b %h want 0 10000004",
                         pred_taken_f, pred_target_f);
    end
  endtask

  task automatic test_alloc;
    @(negedge clk);
    set_upd(1'b1, 32'h1000_0010, 1'b1, 32'h1000_0100, 1'b0, 1'b0, 32'h1000_0014);
    pc_f = 32'h1000_0010;
    #1;
    n_checks++;
    if (mispredict_e !== 1'b1 || flush_d !== 1'b1 || flush_e !== 1'b1) begin
      n_fail++; $display("FAIL alloc_mispredict: got mp=%0b fd=%0b fe=%0b want 1 1 1",
                         mispredict_e, flush_d, flush_e);
    end
    n_checks++;
    if (redirect_pc_e !== 32'h1000_0100) begin
      n_fail++; $display("FAIL alloc_redirect: got %h want 10000100", redirect_pc_e);
    end
    n_checks++;
    if (pred_taken_f !== 1'b0) begin
      n_fail++; $display("FAIL alloc_same_cycle_lookup: got %0b want 0", pred_taken_f);
    end
    @(posedge clk);
    #1;
    upd_valid_e = 1'b0;
    #1;
    n_checks++;
    if (pred_taken_f !== 1'b1 || pred_target_f !== 32'h1000_0100) begin
      n_fail++; $display("FAIL alloc_lookup: got %0b %h want 1 10000100",
                         pred_taken_f, pred_target_f);
    end
    n_checks++;
    if (br_count !== 32'd1 || mp_count !== 32'd1) begin
      n_fail++; $display("FAIL alloc_counts: got br=%0d mp=%0d want 1 1", br_count, mp_count);
    end
  endtask

  task automatic test_saturation;
    logic [31:0] want_tgt;
    for (int i = 0; i < 9; i++) begin
      do_update(32'h1000_0020, sat_taken[i], 32'h1000_0400, 1'b0, 1'b0, 32'h0);
      pc_f = 32'h1000_0020;
      #1;
      want_tgt = sat_pred[i] ? 32'h1000_0400 : 32'h1000_0024;
      n_checks++;
      if (pred_taken_f !== sat_pred[i] || pred_target_f !== want_tgt) begin
        n_fail++; $display("FAIL sat_step%0d: got %0b %h want %0b %h",
                           i, pred_taken_f, pred_target_f, sat_pred[i], want_tgt);
      end
    end
    n_checks++;
    if (br_count !== 32'd10 || mp_count !== 32'd6) begin
      n_fail++; $display("FAIL sat_counts: got br=%0d mp=%0d want 10 6", br_count, mp_count);
    end
  endtask

  task automatic test_alias;
    do_update(32'h1000_0110, 1'b1, 32'h1000_0200, 1'b0, 1'b0, 32'h0);
    pc_f = 32'h1000_0010;
    #1;
    n_checks++;
    if (pred_taken_f !== 1'b0 || pred_target_f !== 32'h1000_0014) begin
      n_fail++; $display("FAIL alias_evicted: got %0b %h want 0 10000014",
                         pred_taken_f, pred_target_f);
    end
    pc_f = 32'h1000_0110;
    #1;
    n_checks++;
    if (pred_taken_f !== 1'b1 || pred_target_f !== 32'h1000_0200) begin
      n_fail++; $display("FAIL alias_new: got %0b %h want 1 10000200",
                         pred_taken_f, pred_target_f);
    end
    n_checks++;
    if (br_count !== 32'd11 || mp_count !== 32'd7) begin
      n_fail++; $display("FAIL alias_counts: got br=%0d mp=%0d want 11 7", br_count, mp_count);
    end
  endtask

  task automatic test_collision;
    @(negedge clk);
    set_upd(1'b1, 32'h1000_0110, 1'b1, 32'h1000_0300, 1'b0, 1'b1, 32'h1000_0300);
    pc_f = 32'h1000_0110;
    #1;
    n_checks++;
    if (mispredict_e !== 1'b0 || flush_e !== 1'b0) begin
      n_fail++; $display("FAIL coll_mispredict: got %0b %0b want 0 0", mispredict_e, flush_e);
    end
    n_checks++;
    if (pred_taken_f !== 1'b1 || pred_target_f !== 32'h1000_0200) begin
      n_fail++; $display("FAIL coll_old_value: got %0b %h want 1 10000200",
                         pred_taken_f, pred_target_f);
    end
    @(posedge clk);
    #1;
    upd_valid_e = 1'b0;
    #1;
    n_checks++;
    if (pred_taken_f !== 1'b1 || pred_target_f !== 32'h1000_0300) begin
      n_fail++; $display("FAIL coll_new_value: got %0b %h want 1 10000300",
                         pred_taken_f, pred_target_f);
    end
    n_checks++;
    if (br_count !== 32'd12 || mp_count !== 32'd7) begin
      n_fail++; $display("FAIL coll_counts: got br=%0d mp=%0d want 12 7", br_count, mp_count);
    end
  endtask

  task automatic test_mispredict_kinds;
    // Direction right, target wrong: jump allocates as strongly taken.
    @(negedge clk);
    set_upd(1'b1, 32'h1000_0040, 1'b1, 32'h1000_0800, 1'b1, 1'b1, 32'h1000_0900);
    #1;
    n_checks++;
    if (mispredict_e !== 1'b1 || redirect_pc_e !== 32'h1000_0800) begin
      n_fail++; $display("FAIL tgt_mispredict: got %0b %h want 1 10000800",
                         mispredict_e, redirect_pc_e);
    end
    @(posedge clk);
    #1;
    upd_valid_e = 1'b0;
    pc_f = 32'h1000_0042;
    #1;
    n_checks++;
    if (pred_taken_f !== 1'b1 || pred_target_f !== 32'h1000_0800) begin
      n_fail++; $display("FAIL jump_misaligned_lookup: got %0b %h want 1 10000800",
                         pred_taken_f, pred_target_f);
    end
    // Predicted taken, actually not taken on a miss: redirect to fall-through, no alloc.
    @(negedge clk);
    set_upd(1'b1, 32'h1000_0050, 1'b0, 32'h1000_0060, 1'b0, 1'b1, 32'h1000_0060);
    #1;
    n_checks++;
    if (mispredict_e !== 1'b1 || redirect_pc_e !== 32'h1000_0054) begin
      n_fail++; $display("FAIL nt_mispredict: got %0b %h want 1 10000054",
                         mispredict_e, redirect_pc_e);
    end
    @(posedge clk);
    #1;
    upd_valid_e = 1'b0;
    pc_f = 32'h1000_0050;
    #1;
    n_checks++;
    if (pred_taken_f !== 1'b0 || pred_target_f !== 32'h1000_0054) begin
      n_fail++; $display("FAIL nt_miss_no_alloc: got %0b %h want 0 10000054",
                         pred_taken_f, pred_target_f);
    end
    n_checks++;
    if (br_count !== 32'd14 || mp_count !== 32'd9) begin
      n_fail++; $display("FAIL kinds_counts: got br=%0d mp=%0d want 14 9", br_count, mp_count);
    end
  endtask

  task automatic test_midreset;
    @(negedge clk);
    pc_f = 32'h1000_0040;
    #1;
    n_checks++;
    if (pred_taken_f !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre: got %0b want 1", pred_taken_f);
    end
    #2;
    n_rst = 1'b0;
    // Update held through reset must be discarded.
    set_upd(1'b1, 32'h1000_0080, 1'b1, 32'h1000_0a00, 1'b0, 1'b0, 32'h0);
    #1;
    n_checks++;
    if (pred_taken_f !== 1'b0 || pred_target_f !== 32'h1000_0044) begin
      n_fail++; $display("FAIL midrst_lookup: got %0b %h want 0 10000044",
                         pred_taken_f, pred_target_f);
    end
    n_checks++;
    if (br_count !== 32'h0 || mp_count !== 32'h0) begin
      n_fail++; $display("FAIL midrst_counts: got br=%0d mp=%0d want 0 0", br_count, mp_count);
    end
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    upd_valid_e = 1'b0;
    pc_f = 32'h1000_0080;
    #1;
    n_checks++;
    if (pred_taken_f !== 1'b0) begin
      n_fail++; $display("FAIL rst_wins_update: got %0b want 0", pred_taken_f);
    end
    pc_f = 32'h1000_0010;
    #1;
    n_checks++;
    if (pred_taken_f !== 1'b0 || pred_target_f !== 32'h1000_0014) begin
      n_fail++; $display("FAIL midrst_orig_pc: got %0b %h want 0 10000014",
                         pred_taken_f, pred_target_f);
    end
    n_checks++;
    if (br_count !== 32'h0 || mp_count !== 32'h0) begin
      n_fail++; $display("FAIL midrst_counts_after: got br=%0d mp=%0d want 0 0",
                         br_count, mp_count);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_saturation();
    test_alias();
    test_collision();
    test_mispredict_kinds();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
